vga_tile_engine: RTL and testbench

Parametrised tile-based VGA scan-out engine; the next generation of the fixed 800x600 tile controller. It generates programmable sync timing and fetches one palette index per tile from a byte-writable, BRAM-style VRAM at 1, 2 or 4 bits per tile. It drives a host-writable palette and emits frame/vblank status for the CPU. It sits between the CPU bus write decoder and the board VGA pins, clocked at the pixel clock.

---
 rtl/vga_tile_engine.sv | 144 ++++++++++++++
 tb/tb_vga_tile_engine.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_engine.sv
// vga_tile_engine: tile-based VGA scan-out with programmable sync timing, VRAM tile fetch and palette lookup
module vga_tile_engine #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP = 56,
  parameter int H_SP = 120,
  parameter int H_BP = 64,
  parameter int V_ACTIVE = 600,
  parameter int V_FP = 37,
  parameter int V_SP = 6,
  parameter int V_BP = 23,
  parameter bit SYNC_NEG = 1'b0,
  parameter int TILE_SHIFT = 5,
  parameter int TILES_H = 28,
  parameter int TILES_V = 18,
  parameter int BPP = 2,
  localparam int VRAM_BYTES = (TILES_H * TILES_V * BPP + 7) / 8,
  localparam int AW = (VRAM_BYTES > 1) ? $clog2(VRAM_BYTES) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           vram_we,
  input  logic [AW-1:0]  vram_waddr,
  input  logic [7:0]     vram_wdata,
  input  logic           pal_we,
  input  logic [BPP-1:0] pal_waddr,
  input  logic [11:0]    pal_wdata,
  output logic [3:0]     vga_red,
  output logic [3:0]     vga_green,
  output logic [3:0]     vga_blue,
  output logic           h_sync,
  output logic           v_sync,
  output logic           vblank,
  output logic           frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SP + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SP + V_BP;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);
  localparam int LB = (BPP == 4) ? 2 : (BPP == 2) ? 1 : 0;
  localparam int SH = 3 - LB;
  localparam int TW = $clog2(TILES_H * TILES_V) + 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [TW-1:0] row_base, t;
  logic x_last, y_last, row_step, active, in_grid;
  logic [AW-1:0] raddr;
  logic [2:0] sub_sh;
  logic [7:0] vram [VRAM_BYTES];
  logic [7:0] rd;
  logic [11:0] pal [2**BPP];
  logic s1_act, s1_grid, s1_hs, s1_vs, s1_vb, s1_fs;
  logic [2:0] s1_sh;
  logic [BPP-1:0] idx;
  logic [11:0] rgb;

  // stage 0 decode: wrap points, visibility and the tile byte address
  always_comb begin
    x_last = 32'(x) == H_TOTAL - 1;
    y_last = 32'(y) == V_TOTAL - 1;
    row_step = ((32'(y) + 1) >> TILE_SHIFT) != (32'(y) >> TILE_SHIFT);
    active = 32'(x) < H_ACTIVE && 32'(y) < V_ACTIVE;
    in_grid = 32'(x >> TILE_SHIFT) < TILES_H && 32'(y >> TILE_SHIFT) < TILES_V;
    t = row_base + TW'(x >> TILE_SHIFT);
    raddr = in_grid ? AW'(t >> SH) : '0;
    sub_sh = 3'(t[SH-1:0]) << LB;
  end

  // raster counters; row_base tracks row*TILES_H by adding TILES_H at each tile-row crossing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      row_base <= '0;
    end else begin
      x <= x_last ? '0 : x + 1'b1;
      if (x_last) begin
        y <= y_last ? '0 : y + 1'b1;
        row_base <= y_last ? '0 : row_step ? row_base + TW'(TILES_H) : row_base;
      end
    end
  end

  // VRAM write port; left without reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (vram_we) vram[vram_waddr] <= vram_wdata;
  end

  // stage 1: synchronous VRAM read (old data on collision) with position flags delayed alongside
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd <= '0;
      s1_act <= 1'b0;
      s1_grid <= 1'b0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_vb <= 1'b0;
      s1_fs <= 1'b0;
      s1_sh <= '0;
    end else begin
      rd <= vram[raddr];
      s1_act <= active;
      s1_grid <= in_grid;
      s1_hs <= 32'(x) >= H_ACTIVE + H_FP && 32'(x) < H_ACTIVE + H_FP + H_SP;
      s1_vs <= 32'(y) >= V_ACTIVE + V_FP && 32'(y) < V_ACTIVE + V_FP + V_SP;
      s1_vb <= 32'(y) >= V_ACTIVE;
      s1_fs <= x == '0 && y == '0;
      s1_sh <= sub_sh;
    end
  end

  // host-writable palette, reset to black/red/green/blue in the low entries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**BPP; i++)
        pal[i] <= (i == 1) ? 12'hF00 : (i == 2) ? 12'h0F0 : (i == 3) ? 12'h00F : 12'h000;
    end else if (pal_we) begin
      pal[pal_waddr] <= pal_wdata;
    end
  end

  // stage 2 decode: LSB-first field extraction, border uses entry 0, blanking forces black
  always_comb begin
    idx = BPP'(rd >> s1_sh);
    rgb = !s1_act ? 12'h000 : s1_grid ? pal[idx] : pal[0];
  end

  // stage 2: output register with sync polarity applied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {vga_red, vga_green, vga_blue} <= 12'h000;
      h_sync <= SYNC_NEG;
      v_sync <= SYNC_NEG;
      vblank <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      {vga_red, vga_green, vga_blue} <= rgb;
      h_sync <= s1_hs ^ SYNC_NEG;
      v_sync <= s1_vs ^ SYNC_NEG;
      vblank <= s1_vb;
      frame_start <= s1_fs;
    end
  end
endmodule

// File: tb/tb_vga_tile_engine.sv
// tb_vga_tile_engine: randomized scan-out check of 2/4/1 bpp builds against a pixel-level model
module tb_vga_tile_engine;
  localparam int HA = 40, HF = 4, HS = 6, HB = 6, HT = HA + HF + HS + HB;
  localparam int VA = 20, VF = 2, VS = 3, VB = 2, VT = VA + VF + VS + VB;
  localparam int TS = 2, TH = 8, TV = 4, FR = HT * VT;
  localparam bit SN = 1'b1;
  localparam logic [15:0] RST = {12'h000, SN, SN, 2'b00};

  logic clk = 1'b0, rst_n = 1'b0;
  logic vwe [3];
  logic [3:0] va [3];
  logic [7:0] vd [3];
  logic pwe [3];
  logic [3:0] pa [3];
  logic [11:0] pd [3];
  int checks = 0, failures = 0, edges = 0;

  always #5 clk = ~clk;

  // edges counted since the last reset release
  always @(posedge clk or negedge rst_n) edges = !rst_n ? 0 : edges + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      if (failures <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int BP = (g == 0) ? 2 : (g == 1) ? 4 : 1;
    localparam int NB = (TH * TV * BP + 7) / 8;
    localparam int AWG = (NB > 1) ? $clog2(NB) : 1;
    logic [3:0] r, gn, b;
    logic hs, vs, vb, fs;
    logic [15:0] o;
    logic [15:0] e = RST;
    logic [7:0] vm [NB];
    logic [11:0] pm [1 << BP];
    logic [7:0] pb = 8'h00;
    int pix = 0, pp = 0, mx, my, mt;
    bit pv = 1'b0;

    initial for (int i = 0; i < NB; i++) vm[i] = 8'h00;

    assign o = {r, gn, b, hs, vs, vb, fs};

    vga_tile_engine #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SP(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SP(VS), .V_BP(VB),
      .SYNC_NEG(SN), .TILE_SHIFT(TS), .TILES_H(TH), .TILES_V(TV), .BPP(BP)
    ) dut (
      .clk(clk), .rst_n(rst_n),
      .vram_we(vwe[g]), .vram_waddr(va[g][AWG-1:0]), .vram_wdata(vd[g]),
      .pal_we(pwe[g]), .pal_waddr(pa[g][BP-1:0]), .pal_wdata(pd[g]),
      .vga_red(r), .vga_green(gn), .vga_blue(b),
      .h_sync(hs), .v_sync(vs), .vblank(vb), .frame_start(fs)
    );

    // model: pixel fetched at one edge appears at the next with the palette as it stands then
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pix = 0;
        pv = 1'b0;
        for (int i = 0; i < (1 << BP); i++)
          pm[i] = (i == 1) ? 12'hF00 : (i == 2) ? 12'h0F0 : (i == 3) ? 12'h00F : 12'h000;
        e = RST;
      end else begin
        if (pv) begin
          mx = pp % HT;
          my = pp / HT;
          mt = (my >> TS) * TH + (mx >> TS);
          e = {(mx >= HA || my >= VA) ? 12'h000 :
               ((mx >> TS) < TH && (my >> TS) < TV) ? pm[(pb >> ((mt % (8 / BP)) * BP)) & ((1 << BP) - 1)] : pm[0],
               SN ^ (mx >= HA + HF && mx < HA + HF + HS),
               SN ^ (my >= VA + VF && my < VA + VF + VS),
               my >= VA, mx == 0 && my == 0};
        end
        mx = pix % HT;
        my = pix / HT;
        mt = (my >> TS) * TH + (mx >> TS);
        pb = ((mx >> TS) < TH && (my >> TS) < TV) ? vm[mt * BP / 8] : 8'h00;
        pp = pix;
        pv = 1'b1;
        pix = (pix + 1) % FR;
        if (vwe[g]) vm[va[g][AWG-1:0]] = vd[g];
        if (pwe[g]) pm[pa[g][BP-1:0]] = pd[g];
      end
    end

    always @(negedge clk) chk($sformatf("scan_bpp%0d_edge%0d", BP, edges), o, e);
  end

  function automatic logic [15:0] o_of(int g);
    return (g == 0) ? gi[0].o : (g == 1) ? gi[1].o : gi[2].o;
  endfunction

  function automatic logic [15:0] e_of(int g);
    return (g == 0) ? gi[0].e : (g == 1) ? gi[1].e : gi[2].e;
  endfunction

  function automatic int bp_of(int g);
    return (g == 0) ? 2 : (g == 1) ? 4 : 1;
  endfunction

  task automatic at(int n);
    while (edges < n) @(negedge clk);
  endtask

  task automatic lit(string nm, int g, int n, logic [15:0] req);
    at(n);
    chk(nm, o_of(g), req);
    chk({nm, "_model"}, e_of(g), req);
  endtask

  task automatic lit_fs(string nm, int n, logic req);
    logic [15:0] v;
    at(n);
    for (int g = 0; g < 3; g++) begin
      v = o_of(g);
      chk(nm, v[0], req);
    end
  endtask

  task automatic wr(int g, int a, logic [7:0] d);
    vwe[g] = 1'b1;
    va[g] = 4'(a);
    vd[g] = d;
    @(negedge clk);
    vwe[g] = 1'b0;
  endtask

  function automatic int px(int x, int y);
    return FR + y * HT + x + 2;
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: run did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int g = 0; g < 3; g++) begin
      vwe[g] = 1'b0; va[g] = '0; vd[g] = '0;
      pwe[g] = 1'b0; pa[g] = '0; pd[g] = '0;
    end
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        vwe[g] = a < (TH * TV * bp_of(g) + 7) / 8;
        va[g] = 4'(a);
        vd[g] = 8'h00;
      end
    end
    @(negedge clk);
    for (int g = 0; g < 3; g++) vwe[g] = 1'b0;
    rst_n = 1'b1;
    lit("reset_edge1", 0, 1, RST);
    lit("first_fs_edge2", 0, 2, {12'h000, SN, SN, 2'b01});
    wr(0, 0, 8'h1B);
    wr(1, 0, 8'h21);
    wr(2, 0, 8'h02);
    // 0x1B LSB-first: tiles 3,2,1,0 -> blue, green, red, black
    lit("bpp2_t0", 0, px(0, 0), {12'h00F, SN, SN, 2'b01});
    lit("bpp4_t0", 1, px(0, 0), {12'hF00, SN, SN, 2'b01});
    lit("bpp1_t0", 2, px(0, 0), {12'h000, SN, SN, 2'b01});
    lit("bpp2_t1", 0, px(4, 0), {12'h0F0, SN, SN, 2'b00});
    lit("bpp4_t1", 1, px(4, 0), {12'h0F0, SN, SN, 2'b00});
    lit("bpp1_t1", 2, px(4, 0), {12'hF00, SN, SN, 2'b00});
    lit("bpp2_t2", 0, px(8, 0), {12'hF00, SN, SN, 2'b00});
    lit("bpp4_t2", 1, px(8, 0), {12'h000, SN, SN, 2'b00});
    lit("bpp1_t2", 2, px(8, 0), {12'h000, SN, SN, 2'b00});
    lit("bpp2_t3", 0, px(12, 0), {12'h000, SN, SN, 2'b00});
    at(px(5, 1) - 2 + 1 - 1);
    wr(0, 0, 8'h00);
    lit("collide_old", 0, px(5, 1), {12'h0F0, SN, SN, 2'b00});
    lit("collide_new", 0, px(6, 1), {12'h000, SN, SN, 2'b00});
    at(px(0, 5));
    for (int g = 0; g < 3; g++) begin pwe[g] = 1'b1; pa[g] = 4'd0; pd[g] = 12'hFFF; end
    @(negedge clk);
    for (int g = 0; g < 3; g++) pwe[g] = 1'b0;
    lit("border_last", 0, px(HA - 1, VA - 1), {12'hFFF, SN, SN, 2'b00});
    lit("blank_x_ha", 0, px(HA, VA - 1), {12'h000, SN, SN, 2'b00});
    lit("vblank_rise", 0, px(0, VA), {12'h000, SN, SN, 2'b10});
    lit("hsync_on", 0, px(HA + HF, VA), {12'h000, !SN, SN, 2'b10});
    lit("vsync_on", 0, px(0, VA + VF), {12'h000, SN, !SN, 2'b10});
    while (edges < 4 * FR) begin
      for (int g = 0; g < 3; g++) begin
        vwe[g] = $urandom_range(5) == 0;
        va[g] = 4'($urandom_range((TH * TV * bp_of(g) + 7) / 8 - 1));
        vd[g] = 8'($urandom);
        pwe[g] = $urandom_range(15) == 0;
        pa[g] = 4'($urandom_range((1 << bp_of(g)) - 1));
        pd[g] = 12'($urandom);
      end
      @(negedge clk);
    end
    for (int g = 0; g < 3; g++) begin vwe[g] = 1'b0; pwe[g] = 1'b0; end
    at(4 * FR + 10 * HT + 7);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) chk($sformatf("async_reset_g%0d", g), o_of(g), RST);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    lit_fs("rerun_fs_edge1", 1, 1'b0);
    lit_fs("rerun_fs_edge2", 2, 1'b1);
    lit_fs("rerun_fs_before_period", FR + 1, 1'b0);
    lit_fs("rerun_fs_period", FR + 2, 1'b1);
    at(FR + 2 * HT);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
